// File: rtl/fnv1a_hash_core_pkg.sv
// Shared constants, state type and helpers for the FNV-1a hash core.
// Build option: FNV_SINGLE_CYCLE_MUL_EN selects the single-cycle multiplier.
package fnv_pkg;

  localparam logic [31:0] FNV32_OFFSET_BASIS = 32'h811C9DC5;
  localparam logic [31:0] FNV32_PRIME        = 32'h01000193;

  // The prime has set bits {0,1,4,7,8,24}; each is one shift-add term.
  localparam int          NUM_TERMS  = 6;
  localparam int          TERM_IDX_W = 3;
  localparam logic [4:0]  TERM_SHIFTS [NUM_TERMS] = '{5'd0, 5'd1, 5'd4, 5'd7, 5'd8, 5'd24};

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } fnv_state_t;

  // Shift amount for term index idx; out-of-range indices contribute shift 0.
  function automatic logic [4:0] term_shift(input logic [TERM_IDX_W-1:0] idx);
    logic [4:0] sh;
    case (idx)
      3'd0:    sh = TERM_SHIFTS[0];
      3'd1:    sh = TERM_SHIFTS[1];
      3'd2:    sh = TERM_SHIFTS[2];
      3'd3:    sh = TERM_SHIFTS[3];
      3'd4:    sh = TERM_SHIFTS[4];
      3'd5:    sh = TERM_SHIFTS[5];
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

  // One full FNV-1a round: (h ^ byte) * prime, truncated to 32 bits.
  function automatic logic [31:0] fnv32_step(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] x;
    x = h ^ {24'h0, b};
    return x * FNV32_PRIME;
  endfunction

endpackage

// File: rtl/fnv1a_hash_core_if.sv
// Byte-stream and readback bundle for fnv1a_hash_core.
// master = upstream producer / readback side, slave = hash core.
interface fnv1a_hash_core_if #(
  parameter int COUNT_W = 16
);
  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               clear;
  logic [31:0]        hash_out;
  logic               busy;
  logic [COUNT_W-1:0] byte_count;

  modport master (
    output in_valid, in_data, clear,
    input  in_ready, hash_out, busy, byte_count
  );

  modport slave (
    input  in_valid, in_data, clear,
    output in_ready, hash_out, busy, byte_count
  );
endinterface

// File: rtl/fnv1a_hash_core_serial_mul.sv
// Serial shift-add multiplier by the FNV-32 prime: one term per cycle.
// Product is combinational on the cycle o_done is high.
module fnv1a_serial_mul
  import fnv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_run,
  input  logic        i_abort,
  input  logic [31:0] i_operand,
  output logic        o_done,
  output logic [31:0] o_product
);

  logic [31:0]           r_x;
  logic [31:0]           r_acc;
  logic [TERM_IDX_W-1:0] r_idx;
  logic [31:0]           w_term;
  logic [31:0]           w_sum;
  logic                  w_last;

  assign w_term    = r_x << term_shift(r_idx);
  assign w_sum     = r_acc + w_term;
  assign w_last    = (r_idx == TERM_IDX_W'(NUM_TERMS - 1));
  assign o_done    = i_run && w_last;
  assign o_product = w_sum;

  // Latch operand on start, then accumulate one shifted term per running cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x   <= '0;
      r_acc <= '0;
      r_idx <= '0;
    end else if (i_abort) begin
      r_x   <= '0;
      r_acc <= '0;
      r_idx <= '0;
    end else if (i_start) begin
      r_x   <= i_operand;
      r_acc <= '0;
      r_idx <= '0;
    end else if (i_run) begin
      r_acc <= w_sum;
      r_idx <= w_last ? '0 : r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/fnv1a_hash_core.sv
// Streaming 32-bit FNV-1a hash core with running digest and byte counter.
// Build option: define FNV_SINGLE_CYCLE_MUL_EN for a combinational multiplier
// (1 byte/cycle, busy tied low); default is the serial shift-add engine.
module fnv1a_hash_core
  import fnv_pkg::*;
#(
  parameter int COUNT_W = 16
) (
  input logic              clk,
  input logic              rst,
  fnv1a_hash_core_if.slave bus
);

  logic [31:0]        r_hash;
  logic [COUNT_W-1:0] r_count;
  logic               w_ready;
  logic               w_busy;
  logic               w_xfer;
  logic               w_commit;
  logic [31:0]        w_next_hash;

`ifdef FNV_SINGLE_CYCLE_MUL_EN

  assign w_ready     = !bus.clear;
  assign w_busy      = 1'b0;
  assign w_xfer      = bus.in_valid && w_ready;
  assign w_commit    = w_xfer;
  assign w_next_hash = fnv32_step(r_hash, bus.in_data);

`else

  fnv_state_t  r_state;
  fnv_state_t  w_state_nxt;
  logic        w_run;
  logic        w_mul_done;
  logic [31:0] w_operand;
  logic [31:0] w_product;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: clear always returns to IDLE; otherwise accept, multiply, commit.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clear) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (bus.in_valid) w_state_nxt = S_MUL;
        S_MUL:   if (w_mul_done)   w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State-decoded outputs: ready only when idle, multiplier runs unless aborted.
  always_comb begin
    w_ready = (r_state == S_IDLE) && !bus.clear;
    w_busy  = (r_state == S_MUL);
    w_run   = (r_state == S_MUL) && !bus.clear;
  end

  assign w_xfer      = bus.in_valid && w_ready;
  assign w_operand   = r_hash ^ {24'h0, bus.in_data};
  assign w_commit    = w_mul_done;
  assign w_next_hash = w_product;

  fnv1a_serial_mul u_mul (
    .clk       (clk),
    .rst       (rst),
    .i_start   (w_xfer),
    .i_run     (w_run),
    .i_abort   (bus.clear),
    .i_operand (w_operand),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );

`endif

  // Committed digest and byte counter; clear restarts, commits only on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hash  <= FNV32_OFFSET_BASIS;
      r_count <= '0;
    end else if (bus.clear) begin
      r_hash  <= FNV32_OFFSET_BASIS;
      r_count <= '0;
    end else if (w_commit) begin
      r_hash  <= w_next_hash;
      r_count <= r_count + 1'b1;
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.busy       = w_busy;
  assign bus.hash_out   = r_hash;
  assign bus.byte_count = r_count;

endmodule

// File: tb/tb_fnv1a_hash_core.sv
// Self-checking bench for fnv1a_hash_core: transaction-level model plus literal digests.
module tb_fnv1a_hash_core;

  localparam int CW = 8;  // narrow counter so wrap-around is reachable quickly
`ifdef FNV_SINGLE_CYCLE_MUL_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 6;
`endif
  localparam logic [31:0] BASIS = 32'h811C9DC5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;

  fnv1a_hash_core_if #(.COUNT_W(CW)) bus ();

  fnv1a_hash_core #(.COUNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference FNV-1a round straight from the algorithm definition.
  function automatic logic [31:0] fnv_ref(input logic [31:0] h, input logic [7:0] b);
    logic [31:0] x;
    x = h ^ {24'h0, b};
    return x * 32'h01000193;
  endfunction

  // Transaction model: a byte accepted when not busy is committed LAT cycles later.
  logic [31:0]   m_hash;
  logic [CW-1:0] m_cnt;
  logic [31:0]   m_pend;
  int            m_rem;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hash <= BASIS; m_cnt <= '0; m_pend <= '0; m_rem <= 0;
    end else if (bus.clear) begin
      m_hash <= BASIS; m_cnt <= '0; m_rem <= 0;
    end else if (m_rem != 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_hash <= m_pend;
        m_cnt  <= m_cnt + 1'b1;
      end
    end else if (bus.in_valid) begin
      if (LAT == 0) begin
        m_hash <= fnv_ref(m_hash, bus.in_data);
        m_cnt  <= m_cnt + 1'b1;
      end else begin
        m_pend <= fnv_ref(m_hash, bus.in_data);
        m_rem  <= LAT;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!rst) begin
      chk("hash_out",   bus.hash_out, m_hash);
      chk("byte_count", 32'(bus.byte_count), 32'(m_cnt));
      chk("busy",       32'(bus.busy), 32'(m_rem != 0));
      chk("in_ready",   32'(bus.in_ready), 32'((m_rem == 0) && !bus.clear));
    end
  end

  // Realign to just after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a byte (call just after a rising edge); returns edge index of transfer.
  task automatic send_byte(input logic [7:0] b, input bit keep, output int t_edge);
    bit done;
    done = 1'b0;
    t_edge = -1;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        t_edge = cyc + 1;
        done = 1'b1;
      end
      @(posedge clk);
    end
    #1;
    bus.in_valid = keep;
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
  endtask

  // Wait (at a falling edge) until the core is idle; bounded.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (bus.in_ready && !bus.busy) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_fail++;
      $display("FAIL idle_timeout: core still busy");
    end
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    idle(1);
    bus.clear = 1'b0;
  endtask

  logic [7:0] foobar [6];
  int t_dummy, t_first, t_commit, nb, nr;

  initial begin
    foobar = '{8'h66, 8'h6f, 8'h6f, 8'h62, 8'h61, 8'h72};
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.clear    = 1'b0;
    idle(2);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_hash",  bus.hash_out, 32'h811C9DC5);
    chk("rst_count", 32'(bus.byte_count), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    idle(1);

    // Single byte "a", busy/ready window
    send_byte(8'h61, 1'b0, t_dummy);
    nb = 0; nr = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.busy) nb++;
      if (!bus.in_ready) nr++;
    end
    chk("a_busy_cycles",  32'(nb), 32'(LAT));
    chk("a_nready_cycles", 32'(nr), 32'(LAT));
    chk("a_hash",   bus.hash_out, 32'hE40C292C);
    chk("a_model",  m_hash, 32'hE40C292C);
    chk("a_count",  32'(bus.byte_count), 32'd1);
    idle(1);

    // "foobar" with in_valid held continuously
    do_clear();
    for (int i = 0; i < 6; i++) begin
      send_byte(foobar[i], (i < 5), t_dummy);
      if (i == 0) t_first = t_dummy;
    end
    t_commit = -1000;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.byte_count == CW'(6)) begin
        t_commit = cyc;
        break;
      end
    end
    chk("foobar_span",  32'(t_commit - t_first + 1), (LAT == 0) ? 32'd6 : 32'd42);
    chk("foobar_hash",  bus.hash_out, 32'hBF9CF968);
    chk("foobar_model", m_hash, 32'hBF9CF968);
    chk("foobar_count", 32'(bus.byte_count), 32'd6);
    idle(1);

    // Clear during the multiply of "b" after "a"
    do_clear();
    send_byte(8'h61, 1'b0, t_dummy);
    wait_idle();
    idle(1);
    send_byte(8'h62, 1'b0, t_dummy);
    idle(1);
    do_clear();
    repeat (8) @(negedge clk);
    chk("clr_hash",  bus.hash_out, 32'h811C9DC5);
    chk("clr_count", 32'(bus.byte_count), 32'd0);
    idle(1);
    send_byte(8'h62, 1'b0, t_dummy);
    wait_idle();
    chk("b_hash",  bus.hash_out, 32'hE70C2DE5);
    chk("b_count", 32'(bus.byte_count), 32'd1);
    idle(1);

    // clear coincident with in_valid: no transfer
    do_clear();
    bus.clear = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h61;
    @(negedge clk);
    chk("clrv_ready", 32'(bus.in_ready), 32'd0);
    idle(1);
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("clrv_count", 32'(bus.byte_count), 32'd0);
    chk("clrv_hash",  bus.hash_out, 32'h811C9DC5);
    idle(1);

    // "foobar" with random gaps on in_valid
    for (int i = 0; i < 6; i++) begin
      idle($urandom_range(0, 3));
      send_byte(foobar[i], 1'b0, t_dummy);
    end
    wait_idle();
    chk("bp_hash",  bus.hash_out, 32'hBF9CF968);
    chk("bp_count", 32'(bus.byte_count), 32'd6);
    idle(1);

    // Asynchronous reset between edges while multiplying
    send_byte(8'h61, 1'b0, t_dummy);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_hash",  bus.hash_out, 32'h811C9DC5);
    chk("arst_count", 32'(bus.byte_count), 32'd0);
    chk("arst_busy",  32'(bus.busy), 32'd0);
    chk("arst_ready", 32'(bus.in_ready), 32'd1);
    idle(1);
    rst = 1'b0;
    idle(1);

    // Counter wrap: 2^CW - 1 bytes, then one more
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      send_byte(8'(i), (i < (1 << CW) - 2), t_dummy);
    end
    wait_idle();
    chk("wrap_full", 32'(bus.byte_count), 32'((1 << CW) - 1));
    idle(1);
    send_byte(8'h5A, 1'b0, t_dummy);
    wait_idle();
    chk("wrap_zero", 32'(bus.byte_count), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
